// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: fetch-stage bundle (WBU commit, IDU handshake, AXI-lite AR/R, status)
//   master: fetch stage drives valid_post/inst/pc, araddr/arvalid, rready, fetch_err, fetch_cnt
//   slave : environment drives commit_valid/npc, ready_post, arready, rdata/rresp/rvalid
interface ifu_fetch_if;
  logic        commit_valid;
  logic [31:0] npc;
  logic        valid_post;
  logic        ready_post;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        fetch_err;
  logic [63:0] fetch_cnt;
  modport master (
    input  commit_valid, npc, ready_post, arready, rdata, rresp, rvalid,
    output valid_post, inst, pc, araddr, arvalid, rready, fetch_err, fetch_cnt
  );
  modport slave (
    output commit_valid, npc, ready_post, arready, rdata, rresp, rvalid,
    input  valid_post, inst, pc, araddr, arvalid, rready, fetch_err, fetch_cnt
  );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: multicycle instruction fetch, one AXI-lite read per instruction, hands off to IDU, waits for WBU commit
//   clk, rst (async, active-low), bus (ifu_fetch_if.master)
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ERR_INST = 32'h0010_0073
) (
  input logic clk,
  input logic rst,
  ifu_fetch_if.master bus
);
  typedef enum logic [2:0] {
    BOOT,
    WAIT_ARREADY,
    WAIT_RVALID,
    WAIT_READY,
    WAIT_COMMIT
  } state_t;
  state_t      state, state_nx;
  logic [31:0] pc_r, inst_r, pc_out;
  logic        err_r;
  logic [63:0] cnt_r;
  logic        r_fire, post_fire, commit_fire;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= BOOT;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    r_fire = state == WAIT_RVALID && bus.rvalid;
    post_fire = state == WAIT_READY && bus.ready_post;
    commit_fire = state == WAIT_COMMIT && bus.commit_valid;
    state_nx = state == BOOT ? WAIT_ARREADY :
               state == WAIT_ARREADY && bus.arready ? WAIT_RVALID :
               r_fire ? WAIT_READY :
               post_fire ? WAIT_COMMIT :
               commit_fire ? WAIT_ARREADY : state;
  end
  // handshakes decode from state only, so no input reaches an output combinationally
  assign bus.arvalid = state == WAIT_ARREADY;
  assign bus.rready = state == WAIT_RVALID;
  assign bus.valid_post = state == WAIT_READY;
  assign bus.araddr = pc_r;
  assign bus.inst = inst_r;
  assign bus.pc = pc_out;
  assign bus.fetch_err = err_r;
  assign bus.fetch_cnt = cnt_r;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc_r <= RESET_PC;
      inst_r <= '0;
      pc_out <= RESET_PC;
      err_r <= 1'b0;
      cnt_r <= '0;
    end else begin
      if (r_fire) begin
        inst_r <= bus.rresp == 2'b00 ? bus.rdata : ERR_INST;
        pc_out <= pc_r;
      end
      // the PC is word-aligned by dropping the low bits; misalignment is only flagged
      if (commit_fire) pc_r <= {bus.npc[31:2], 2'b00};
      if ((r_fire && bus.rresp != 2'b00) || (commit_fire && bus.npc[1:0] != 2'b00)) err_r <= 1'b1;
      if (post_fire) cnt_r <= cnt_r + 64'd1;
    end
endmodule
